// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, iterative shift-add multiplier, EX/MEM latch
module exe_stage (
    input  logic        clk,
    input  logic        clrn,
    input  logic        evalid,
    input  logic        eflush,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [3:0]  ealuc,
    input  logic        ealuimm,
    input  logic [4:0]  edestReg,
    input  logic [31:0] eqa,
    input  logic [31:0] eqb,
    input  logic [31:0] eimm32,
    output logic        estall,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mwmem,
    output logic [4:0]  mdestReg,
    output logic [31:0] mr,
    output logic [31:0] mqb
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SLL = 4'h5;
    localparam logic [3:0] OP_SRL = 4'h6;
    localparam logic [3:0] OP_SRA = 4'h7;
    localparam logic [3:0] OP_SLT = 4'h8;
    localparam logic [3:0] OP_LUI = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;

    logic [1:0]  state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;

    logic        mwreg_q, mwreg_d;
    logic        mm2reg_q, mm2reg_d;
    logic        mwmem_q, mwmem_d;
    logic [4:0]  mdest_q, mdest_d;
    logic [31:0] mr_q, mr_d;
    logic [31:0] mqb_q, mqb_d;

    logic [31:0] opb;
    logic [31:0] alu_res;
    logic        is_mul;

    assign opb    = ealuimm ? eimm32 : eqb;
    assign is_mul = (ealuc == OP_MUL);

    // single-cycle ALU result; mul and reserved codes produce 0 here
    always_comb begin
        alu_res = 32'd0;
        case (ealuc)
            OP_ADD:  alu_res = eqa + opb;
            OP_SUB:  alu_res = eqa - opb;
            OP_AND:  alu_res = eqa & opb;
            OP_OR:   alu_res = eqa | opb;
            OP_XOR:  alu_res = eqa ^ opb;
            OP_SLL:  alu_res = eqa << opb[4:0];
            OP_SRL:  alu_res = eqa >> opb[4:0];
            OP_SRA:  alu_res = $unsigned($signed(eqa) >>> opb[4:0]);
            OP_SLT:  alu_res = {31'd0, ($signed(eqa) < $signed(opb))};
            OP_LUI:  alu_res = opb << 16;
            default: alu_res = 32'd0;
        endcase
    end

    // stall covers the accept cycle of a mul and every BUSY cycle; DONE lets ID/EX advance
    assign estall = clrn & (((state_q == ST_IDLE) & evalid & is_mul & ~eflush)
                            | (state_q == ST_BUSY));

    // next-state: sequencer, multiplier datapath and EX/MEM contents (bubble by default)
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mwreg_d  = 1'b0;
        mm2reg_d = 1'b0;
        mwmem_d  = 1'b0;
        mdest_d  = 5'd0;
        mr_d     = 32'd0;
        mqb_d    = 32'd0;
        if (eflush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (evalid) begin
                        if (is_mul) begin
                            mcand_d  = eqa;
                            mplier_d = opb;
                            acc_d    = 32'd0;
                            cnt_d    = 5'd0;
                            state_d  = ST_BUSY;
                        end else begin
                            mwreg_d  = ewreg;
                            mm2reg_d = em2reg;
                            mwmem_d  = ewmem;
                            mdest_d  = edestReg;
                            mr_d     = alu_res;
                            mqb_d    = eqb;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // ID/EX was frozen by the stall, so its controls still belong to the mul
                    mwreg_d  = ewreg;
                    mm2reg_d = em2reg;
                    mwmem_d  = ewmem;
                    mdest_d  = edestReg;
                    mr_d     = acc_q;
                    mqb_d    = eqb;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // state and EX/MEM registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q  <= ST_IDLE;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 32'd0;
            cnt_q    <= 5'd0;
            mwreg_q  <= 1'b0;
            mm2reg_q <= 1'b0;
            mwmem_q  <= 1'b0;
            mdest_q  <= 5'd0;
            mr_q     <= 32'd0;
            mqb_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mwreg_q  <= mwreg_d;
            mm2reg_q <= mm2reg_d;
            mwmem_q  <= mwmem_d;
            mdest_q  <= mdest_d;
            mr_q     <= mr_d;
            mqb_q    <= mqb_d;
        end
    end

    assign mwreg    = mwreg_q;
    assign mm2reg   = mm2reg_q;
    assign mwmem    = mwmem_q;
    assign mdestReg = mdest_q;
    assign mr       = mr_q;
    assign mqb      = mqb_q;

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage pipelined CPU: takes decoded operands and control from ID/EX, computes the ALU result, and registers everything into the EX/MEM latch that feeds data memory and MEM/WB. Single-cycle ALU ops complete in one clock. MUL runs on an iterative 32-step shift-add multiplier that stalls the front of the pipeline until the product is ready.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on posedge
- clrn  in  1  synchronous active-low reset, sampled on posedge clk
- evalid  in  1  ID/EX holds a real instruction (0 = bubble)
- eflush  in  1  synchronous flush: abort work and load a bubble into EX/MEM
- ewreg, em2reg, ewmem  in  1 each  register-write, load-select and memory-write controls
- ealuc  in  4  ALU op: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 lui, A mul; B–F reserved
- ealuimm  in  1  B operand select: 1 = eimm32, 0 = eqb
- edestReg  in  5  destination register
- eqa, eqb, eimm32  in  32 each  A operand, rt value, sign-extended immediate
- estall  out  1  freeze PC, IF/ID and ID/EX (combinational)
- mwreg, mm2reg, mwmem  out  1 each  registered controls to MEM
- mdestReg  out  5  registered destination
- mr  out  32  registered ALU result / memory address
- mqb  out  32  registered store data

## Operation
- Operands: A = eqa; B = ealuimm ? eimm32 : eqb.
- Arithmetic: add and sub wrap modulo 2^32, with no overflow flag.
- Shifts: the shift amount is B[4:0]. sra is arithmetic on A.
- slt: {31'b0, $signed(A) < $signed(B)}.
- lui: B << 16.
- Reserved ealuc codes give result 0; controls still pass through.
- Bubble: mwreg = mwmem = mm2reg = 0, mdestReg = 0, mr = 0, mqb = 0.
- Normal load of EX/MEM: controls and edestReg pass through, mr = result, mqb = eqb.
- FSM states: IDLE, BUSY, DONE.
- IDLE, evalid = 1, op ≠ mul:
  - EX/MEM loads the normal result.
  - State stays IDLE.
- IDLE, evalid = 0: EX/MEM loads a bubble.
- IDLE, evalid = 1, op = mul:
  - Latch mcand = A, mplier = B, acc = 0, cnt = 0.
  - Go to BUSY.
  - EX/MEM loads a bubble.
- BUSY, each cycle:
  - If mplier[0], acc = acc + mcand (32-bit, wrapping).
  - Then mcand <<= 1, mplier >>= 1, cnt += 1.
  - When the step with cnt = 31 completes, go to DONE.
  - EX/MEM loads a bubble.
- DONE:
  - EX/MEM loads controls from the ID/EX inputs, which are held stable by the stall, with mr = acc and mqb = eqb.
  - Go to IDLE.
- Product: only the low 32 bits are kept, so signed and unsigned results are identical.
- estall = clrn & ((IDLE & evalid & ealuc == mul & ~eflush) | BUSY).
- eflush has priority over everything except reset:
  - State goes to IDLE, EX/MEM loads a bubble, and multiplier registers are don't-care.
  - A flush in any state aborts the multiply.
- Reset (clrn = 0 at posedge), regardless of state, including mid-multiply:
  - All outputs go to 0, state goes to IDLE, and acc/cnt go to 0.
  - estall is 0 while clrn = 0.

## Timing
- Non-mul latency: 1 cycle. Inputs at posedge N appear on m* after posedge N.
- Mul latency: 34 posedges from the accept edge to the result edge.
  - 1 accept edge, 32 BUSY edges, 1 DONE edge.
  - estall is high for 33 consecutive cycles.
  - EX/MEM shows 33 bubbles, then the product.
- A new instruction enters on the posedge after DONE with no gap.
- Back-to-back muls: the second is accepted in the IDLE cycle that follows DONE.
- estall is combinational from evalid/ealuc/state. Upstream must not combinationally feed estall back into evalid/ealuc.

## Test plan
- Reset: hold clrn = 0 with random inputs → all m* = 0 and estall = 0. Release, then add 5+7 → mr = 12 one cycle later.
- ALU sweep with ealuimm = 0:
  - sub 3−5 → 0xFFFFFFFE
  - sra 0x80000000 by 4 → 0xF8000000
  - slt −1 vs 1 → 1
  - lui with imm 0x1234 → 0x12340000
- Load/store path: add eqa = 0x100, eimm32 = 8, ealuimm = 1, ewmem = 1, eqb = 0xDEADBEEF → mr = 0x108, mqb = 0xDEADBEEF, mwmem = 1.
- mul 7×6:
  - estall high exactly 33 cycles.
  - 33 bubbles on EX/MEM, then mr = 42 with mwreg = 1 and mdestReg as given.
  - Following add enters the next cycle.
- mul 0xFFFFFFFF×2 → mr = 0xFFFFFFFE. Back-to-back mul 3×3 → second product 9 exactly 34 cycles after the first.
- Abort cases:
  - eflush at BUSY cycle 10 → estall drops next cycle, EX/MEM holds a bubble, and no product appears.
  - clrn = 0 at BUSY cycle 20 → all outputs 0, then a fresh mul 2×2 gives 4.
